// File: rtl/mmcm_ps_pkg.sv
// mmcm_ps_pkg: shared types and constants for the multi-channel MMCM phase stepper
package mmcm_ps_pkg;
    typedef enum logic [1:0] {IDLE, STEP, WAIT, DRAIN} ps_state_t;
    localparam logic MODE_ABS = 1'b0;
    localparam logic MODE_REL = 1'b1;
    localparam int DEFAULT_DONE_TIMEOUT = 1024;
endpackage

// File: rtl/mmcm_ps_channel.sv
// mmcm_ps_channel: one MMCM dynamic phase-shift stepper with abort, readback and PSDONE timeout
module mmcm_ps_channel
    import mmcm_ps_pkg::*;
#(
    parameter int PHASE_WIDTH = 32,
    parameter int DONE_TIMEOUT = DEFAULT_DONE_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PHASE_WIDTH-1:0] target,
    input  logic                   mode_rel,
    input  logic                   configure,
    input  logic                   abort,
    input  logic                   ps_done,
    output logic                   configured,
    output logic                   busy,
    output logic                   error,
    output logic                   ps_en,
    output logic                   ps_inc_dec,
    output logic [PHASE_WIDTH-1:0] position
);
    localparam int TW = $clog2(DONE_TIMEOUT);
    localparam logic [PHASE_WIDTH-1:0] ONE = 1;
    ps_state_t state, state_n;
    logic [PHASE_WIDTH-1:0] goal;
    logic [TW-1:0] count;
    logic abort_q, step, timeout;
    assign timeout = count == TW'(DONE_TIMEOUT - 1);
    assign busy = state != IDLE;
    always_comb begin
        state_n = state;
        step = 1'b0;
        case (state)
            IDLE: state_n = configure ? STEP : IDLE;
            STEP: begin
                step = !abort && goal != position;
                state_n = step ? WAIT : IDLE;
            end
            WAIT: state_n = ps_done ? ((abort || abort_q) ? IDLE : STEP) : (timeout ? IDLE : WAIT);
            default: state_n = IDLE;
        endcase
    end
    // ps_en is registered, so the pulse lands in the first WAIT cycle where the timeout count is 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            position <= '0;
            goal <= '0;
            count <= '0;
            abort_q <= 1'b0;
            ps_en <= 1'b0;
            ps_inc_dec <= 1'b0;
            error <= 1'b0;
            configured <= 1'b0;
        end else begin
            state <= state_n;
            configured <= state == IDLE && !error && !configure;
            ps_en <= step;
            count <= step ? '0 : count + TW'(1);
            abort_q <= state == WAIT && (abort_q || abort);
            if (step) ps_inc_dec <= $signed(goal) > $signed(position);
            if (state == IDLE && configure) begin
                goal <= mode_rel == MODE_REL ? position + target : target;
                error <= 1'b0;
            end
            if (state == WAIT && ps_done) position <= ps_inc_dec ? position + ONE : position - ONE;
            if (state == WAIT && !ps_done && timeout) error <= 1'b1;
        end
    end
endmodule

// File: rtl/mmcm_phaseshift_multi.sv
// mmcm_phaseshift_multi: NUM_CH independent MMCM phase steppers with aggregate status
module mmcm_phaseshift_multi
    import mmcm_ps_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int PHASE_WIDTH = 32,
    parameter int DONE_TIMEOUT = DEFAULT_DONE_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH*PHASE_WIDTH-1:0] target,
    input  logic [NUM_CH-1:0]             mode_rel,
    input  logic [NUM_CH-1:0]             configure,
    input  logic [NUM_CH-1:0]             abort,
    output logic [NUM_CH-1:0]             configured,
    output logic [NUM_CH-1:0]             busy,
    output logic [NUM_CH-1:0]             error,
    output logic [NUM_CH*PHASE_WIDTH-1:0] position,
    output logic                          all_configured,
    output logic                          any_error,
    input  logic [NUM_CH-1:0]             ps_done,
    output logic [NUM_CH-1:0]             ps_en,
    output logic [NUM_CH-1:0]             ps_inc_dec
);
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        mmcm_ps_channel #(.PHASE_WIDTH(PHASE_WIDTH), .DONE_TIMEOUT(DONE_TIMEOUT)) u_ch (
            .clk(clk),
            .rst(rst),
            .target(target[i*PHASE_WIDTH +: PHASE_WIDTH]),
            .mode_rel(mode_rel[i]),
            .configure(configure[i]),
            .abort(abort[i]),
            .ps_done(ps_done[i]),
            .configured(configured[i]),
            .busy(busy[i]),
            .error(error[i]),
            .ps_en(ps_en[i]),
            .ps_inc_dec(ps_inc_dec[i]),
            .position(position[i*PHASE_WIDTH +: PHASE_WIDTH])
        );
    end
    assign all_configured = &configured;
    assign any_error = |error;
endmodule

// File: tb/tb_mmcm_phaseshift_multi.sv
// tb_mmcm_phaseshift_multi: directed scenarios against a 3-cycle PSDONE MMCM model
module tb_mmcm_phaseshift_multi;
    localparam int N = 4, W = 32;
    logic clk = 1'b0, rst = 1'b1;
    logic [N*W-1:0] target = '0;
    logic [N-1:0] mode_rel = '0, configure = '0, abort = '0, respond = '1, force_done = '0;
    logic [N-1:0] ps_done, configured, busy, error, ps_en, ps_inc_dec;
    logic [N*W-1:0] position;
    logic all_configured, any_error;
    logic [2:0] sh [N] = '{default: '0};
    int inc_cnt [N] = '{default: 0};
    int dec_cnt [N] = '{default: 0};
    int tests = 0, fails = 0;

    mmcm_phaseshift_multi #(.NUM_CH(N), .PHASE_WIDTH(W), .DONE_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .target(target), .mode_rel(mode_rel), .configure(configure),
        .abort(abort), .configured(configured), .busy(busy), .error(error), .position(position),
        .all_configured(all_configured), .any_error(any_error), .ps_done(ps_done),
        .ps_en(ps_en), .ps_inc_dec(ps_inc_dec)
    );

    always #5 clk = ~clk;

    // MMCM model: PSDONE three cycles after PSEN unless withheld
    always @(posedge clk) begin
        for (int c = 0; c < N; c++) begin
            sh[c] <= {sh[c][1:0], ps_en[c] & respond[c]};
            if (ps_en[c]) begin
                if (ps_inc_dec[c]) inc_cnt[c]++;
                else dec_cnt[c]++;
            end
        end
    end
    always_comb for (int c = 0; c < N; c++) ps_done[c] = sh[c][2] | force_done[c];

    function automatic logic [W-1:0] pos(input int c);
        return position[c*W +: W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int c, input logic [W-1:0] val, input logic rel);
        target[c*W +: W] = val;
        mode_rel[c] = rel;
        configure[c] = 1'b1;
        tick();
        configure[c] = 1'b0;
    endtask

    task automatic wait_cfg(input int c, output int cyc);
        cyc = -1;
        for (int i = 0; i < 400; i++) begin
            if (configured[c]) begin
                cyc = i;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        tests++; if (configured !== 4'h0 || busy !== 4'h0 || error !== 4'h0) begin fails++; $display("FAIL reset_status: cfg=%b busy=%b err=%b want 0000", configured, busy, error); end
        tests++; if (ps_en !== 4'h0 || ps_inc_dec !== 4'h0 || position !== '0) begin fails++; $display("FAIL reset_ps: en=%b incdec=%b pos=%h want zeros", ps_en, ps_inc_dec, position); end
        rst = 1'b0;
        tick();
        tests++; if (configured !== 4'hF || all_configured !== 1'b1) begin fails++; $display("FAIL reset_release: cfg=%b all=%b want 1111/1", configured, all_configured); end
    endtask

    task automatic test_abs();
        int i0 = inc_cnt[0], d0 = dec_cnt[0];
        int others = inc_cnt[1] + inc_cnt[2] + inc_cnt[3] + dec_cnt[1] + dec_cnt[2] + dec_cnt[3];
        int cyc;
        start(0, 32'd5, 1'b0);
        wait_cfg(0, cyc);
        tests++; if (cyc < 0) begin fails++; $display("FAIL abs_done: configured never rose"); end
        tests++; if (inc_cnt[0] - i0 !== 5 || dec_cnt[0] - d0 !== 0) begin fails++; $display("FAIL abs_steps: inc=%0d dec=%0d want 5/0", inc_cnt[0] - i0, dec_cnt[0] - d0); end
        tests++; if (pos(0) !== 32'd5 || busy[0] !== 1'b0 || ps_inc_dec[0] !== 1'b1) begin fails++; $display("FAIL abs_pos: pos=%h busy=%b incdec=%b want 5/0/1", pos(0), busy[0], ps_inc_dec[0]); end
        tests++; if (inc_cnt[1] + inc_cnt[2] + inc_cnt[3] + dec_cnt[1] + dec_cnt[2] + dec_cnt[3] !== others || position[N*W-1:W] !== '0) begin fails++; $display("FAIL abs_isolation: other channels moved pos=%h", position); end
    endtask

    task automatic test_rel();
        int d0, i0, cyc;
        start(1, 32'd5, 1'b0);
        wait_cfg(1, cyc);
        d0 = dec_cnt[1];
        i0 = inc_cnt[1];
        start(1, 32'hFFFF_FFF9, 1'b1);
        wait_cfg(1, cyc);
        tests++; if (dec_cnt[1] - d0 !== 7 || inc_cnt[1] - i0 !== 0) begin fails++; $display("FAIL rel_steps: dec=%0d inc=%0d want 7/0", dec_cnt[1] - d0, inc_cnt[1] - i0); end
        tests++; if (pos(1) !== 32'hFFFF_FFFE) begin fails++; $display("FAIL rel_pos: got %h want fffffffe", pos(1)); end
        d0 = dec_cnt[1];
        start(1, 32'hFFFF_FFFE, 1'b0);
        tests++; if (configured[1] !== 1'b0 || busy[1] !== 1'b1) begin fails++; $display("FAIL lat_c1: cfg=%b busy=%b want 0/1", configured[1], busy[1]); end
        tick();
        tests++; if (configured[1] !== 1'b0 || busy[1] !== 1'b0) begin fails++; $display("FAIL lat_c2: cfg=%b busy=%b want 0/0", configured[1], busy[1]); end
        tick();
        tests++; if (configured[1] !== 1'b1) begin fails++; $display("FAIL lat_c3: cfg=%b want 1", configured[1]); end
        tests++; if (dec_cnt[1] - d0 !== 0 || inc_cnt[1] - i0 !== 0) begin fails++; $display("FAIL lat_noen: pulses=%0d want 0", dec_cnt[1] - d0 + inc_cnt[1] - i0); end
    endtask

    task automatic test_abort();
        int i0 = inc_cnt[2], n = 0, cyc;
        start(2, 32'd10, 1'b0);
        for (int k = 0; k < 200 && n < 3; k++) begin
            if (ps_en[2]) n++;
            if (n < 3) tick();
        end
        tests++; if (n !== 3) begin fails++; $display("FAIL abort_third_en: saw %0d want 3", n); end
        abort[2] = 1'b1;
        tick();
        abort[2] = 1'b0;
        wait_cfg(2, cyc);
        tests++; if (pos(2) !== 32'd3 || cyc < 0) begin fails++; $display("FAIL abort_pos: pos=%h cyc=%0d want 3", pos(2), cyc); end
        repeat (20) tick();
        tests++; if (inc_cnt[2] - i0 !== 3 || busy[2] !== 1'b0 || pos(2) !== 32'd3) begin fails++; $display("FAIL abort_stopped: steps=%0d busy=%b pos=%h want 3/0/3", inc_cnt[2] - i0, busy[2], pos(2)); end
    endtask

    task automatic test_timeout();
        int cyc = -1;
        respond[3] = 1'b0;
        start(3, 32'd3, 1'b0);
        for (int k = 0; k < 50 && !ps_en[3]; k++) tick();
        tests++; if (ps_en[3] !== 1'b1) begin fails++; $display("FAIL to_en: ps_en=%b want 1", ps_en[3]); end
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (error[3]) begin
                cyc = k;
                break;
            end
        end
        tests++; if (cyc !== 16) begin fails++; $display("FAIL to_latency: error after %0d cycles want 16", cyc); end
        tests++; if (any_error !== 1'b1 || error[2:0] !== 3'b000 || pos(3) !== '0) begin fails++; $display("FAIL to_state: any=%b err=%b pos=%h want 1/0000-low/0", any_error, error, pos(3)); end
        tick();
        tests++; if (configured[3] !== 1'b0 || busy[3] !== 1'b0) begin fails++; $display("FAIL to_idle: cfg=%b busy=%b want 0/0", configured[3], busy[3]); end
        respond[3] = 1'b1;
        start(3, 32'd3, 1'b0);
        tests++; if (error[3] !== 1'b0 || any_error !== 1'b0) begin fails++; $display("FAIL to_clear: err=%b any=%b want 0/0", error[3], any_error); end
        wait_cfg(3, cyc);
        tests++; if (pos(3) !== 32'd3 || configured[3] !== 1'b1) begin fails++; $display("FAIL to_recover: pos=%h cfg=%b want 3/1", pos(3), configured[3]); end
    endtask

    task automatic test_concurrent();
        int isum = inc_cnt[0] + inc_cnt[1] + inc_cnt[2] + inc_cnt[3];
        int dsum = dec_cnt[0] + dec_cnt[1] + dec_cnt[2] + dec_cnt[3];
        logic [N-1:0] prev;
        logic done = 1'b0;
        target = {32'hFFFF_FFFA, 32'd0, 32'd4, 32'd8};
        mode_rel = 4'b0010;
        configure = '1;
        tick();
        configure = '0;
        repeat (6) tick();
        tests++; if (busy !== 4'hF) begin fails++; $display("FAIL conc_busy: busy=%b want 1111", busy); end
        target = {4{32'd100}};
        mode_rel = '0;
        configure = '1;
        tick();
        configure = '0;
        prev = configured;
        for (int k = 0; k < 400; k++) begin
            prev = configured;
            tick();
            if (all_configured) begin
                done = 1'b1;
                break;
            end
        end
        tests++; if (done !== 1'b1 || prev !== 4'b0111) begin fails++; $display("FAIL conc_all: done=%b prev_cfg=%b want 1/0111", done, prev); end
        tests++; if (position !== {32'hFFFF_FFFA, 32'd0, 32'd2, 32'd8}) begin fails++; $display("FAIL conc_pos: got %h want fffffffa000000000000000200000008", position); end
        tests++; if (inc_cnt[0] + inc_cnt[1] + inc_cnt[2] + inc_cnt[3] - isum !== 7 || dec_cnt[0] + dec_cnt[1] + dec_cnt[2] + dec_cnt[3] - dsum !== 12) begin fails++; $display("FAIL conc_steps: inc=%0d dec=%0d want 7/12", inc_cnt[0] + inc_cnt[1] + inc_cnt[2] + inc_cnt[3] - isum, dec_cnt[0] + dec_cnt[1] + dec_cnt[2] + dec_cnt[3] - dsum); end
    endtask

    task automatic test_reset_mid();
        start(0, 32'd20, 1'b0);
        for (int k = 0; k < 50 && !ps_en[0]; k++) tick();
        tests++; if (ps_en[0] !== 1'b1) begin fails++; $display("FAIL rmid_en: ps_en=%b want 1", ps_en[0]); end
        rst = 1'b1;
        tick();
        tests++; if (configured !== 4'h0 || busy !== 4'h0 || error !== 4'h0 || all_configured !== 1'b0 || any_error !== 1'b0) begin fails++; $display("FAIL rmid_status: cfg=%b busy=%b err=%b all=%b any=%b want zeros", configured, busy, error, all_configured, any_error); end
        tests++; if (ps_en !== 4'h0 || ps_inc_dec !== 4'h0 || position !== '0) begin fails++; $display("FAIL rmid_ps: en=%b incdec=%b pos=%h want zeros", ps_en, ps_inc_dec, position); end
        rst = 1'b0;
        repeat (3) tick();
        force_done = '1;
        tick();
        force_done = '0;
        repeat (3) tick();
        tests++; if (position !== '0 || configured !== 4'hF || busy !== 4'h0) begin fails++; $display("FAIL rmid_late_done: pos=%h cfg=%b busy=%b want 0/1111/0000", position, configured, busy); end
    endtask

    initial begin
        test_reset();
        test_abs();
        test_rel();
        test_abort();
        test_timeout();
        test_concurrent();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mmcm_phaseshift_multi.md
Name: mmcm_phaseshift_multi

Overview:
- Multi-channel successor to the single-MMCM phase stepper. It drives NUM_CH independent MMCM dynamic-phase-shift ports from one fabric clock.
- New per channel:
  - absolute or relative targeting;
  - live position readback;
  - abort;
  - PSDONE timeout with a sticky error.
- Sits between the delay-unit control registers and the MMCM PSEN/PSINCDEC/PSDONE pins. Position counts only steps the MMCM has acknowledged.

Parameters:
- NUM_CH, 4: number of independent MMCM phase-shift channels (≥1).
- PHASE_WIDTH, 32: width of target/position, two's complement.
- DONE_TIMEOUT, 1024: cycles to wait for ps_done after a ps_en before declaring error (≥2).

Ports:
- clk  in  1  fabric and MMCM PSCLK clock.
- rst  in  1  synchronous, active-high reset.
- target  in  NUM_CH*PHASE_WIDTH  per-channel goal, channel i at [i*PHASE_WIDTH +: PHASE_WIDTH]; absolute position or signed delta.
- mode_rel  in  NUM_CH  per channel: 1 = target is a delta from current position, 0 = target is absolute.
- configure  in  NUM_CH  per-channel start pulse.
- abort  in  NUM_CH  per-channel stop request.
- configured  out  NUM_CH  high while the channel is idle, goal reached, no error.
- busy  out  NUM_CH  high while the channel is moving.
- error  out  NUM_CH  sticky PSDONE-timeout flag.
- position  out  NUM_CH*PHASE_WIDTH  acknowledged phase position per channel.
- all_configured  out  1  AND of configured.
- any_error  out  1  OR of error.
- ps_done  in  NUM_CH  from MMCM PSDONE.
- ps_en  out  NUM_CH  to MMCM PSEN, single-cycle pulses.
- ps_inc_dec  out  NUM_CH  to MMCM PSINCDEC (1 = increment).

Behaviour:
- Reset: state IDLE; position=0, goal=0, ps_en=0, ps_inc_dec=0, error=0, busy=0, configured=0.
  - configured rises the cycle after rst deasserts, because it is registered from IDLE.
- Channels are fully independent. Top-level outputs are pure AND/OR of channel outputs (combinational).
- Per-channel FSM states: IDLE, STEP, WAIT, DRAIN.
- IDLE:
  - configured=!error, busy=0.
  - On configure: goal <= mode_rel ? position+target : target (wraps modulo 2^PHASE_WIDTH); error <= 0; go to STEP.
  - abort in IDLE is ignored.
- STEP: busy=1.
  - If abort: go to IDLE.
  - Else if goal==position: go to IDLE; configured is high next cycle.
  - Else: ps_en=1 for exactly one cycle, ps_inc_dec = (signed goal > signed position); clear timeout counter; go to WAIT.
- WAIT: busy=1, ps_en=0, ps_inc_dec held, timeout counter increments each cycle.
  - If ps_done: position += ps_inc_dec ? +1 : -1. Then go to IDLE if an abort has been latched during WAIT, else go to STEP.
  - Else if counter == DONE_TIMEOUT-1: error <= 1, position unchanged, go to IDLE.
  - ps_done wins over timeout in the same cycle.
  - abort in WAIT is latched; the in-flight step always completes.
- DRAIN: reserved encoding for abort-after-done bookkeeping. The implementation may fold it into WAIT, but the behaviour must be exactly as stated above.
- configure while not IDLE is ignored. It does not retarget.
- ps_done outside WAIT is ignored.
- Step cadence: ps_en at cycle t; ps_done earliest at t+1; next ps_en at the earliest 2 cycles after ps_done. ps_en is never reasserted before ps_done.
- Latency: configure at cycle 0 with goal==position → configured high at cycle 3 (IDLE→STEP at 1, STEP→IDLE at 2, registered output at 3).
- rst mid-operation: returns to the reset state immediately. position resets to 0 even though the MMCM retains its phase, so the MMCM must be reset alongside.

Decomposition:
- Package mmcm_ps_pkg holds:
  - ps_state_t enum (IDLE, STEP, WAIT, DRAIN);
  - MODE_ABS=1'b0 and MODE_REL=1'b1 constants;
  - the default DONE_TIMEOUT localparam.
- Sub-module mmcm_ps_channel: one FSM plus position/goal/timeout registers, with PHASE_WIDTH and DONE_TIMEOUT parameters. The top level is a generate loop of NUM_CH instances plus the AND/OR reduction.

Test Plan:
- Ch0: absolute target=5, MMCM model answers ps_done 3 cycles after ps_en → exactly 5 ps_en pulses with ps_inc_dec=1, position=5, configured high, other channels untouched.
- Ch1: from position 5, relative target=-7 → 7 decrement steps, position=-2 (0xFFFFFFFE). Then absolute target=-2 → no ps_en pulse and configured back at cycle 3.
- Ch2: target=10, abort pulsed during the 3rd WAIT → 3rd ps_done accepted, position=3, IDLE, no further ps_en.
- Ch3: model withholds ps_done, DONE_TIMEOUT=16 → error rises 16 cycles after ps_en, any_error=1, position unchanged. Next configure clears error.
- Concurrent: all channels configured in the same cycle to different targets, plus configure re-pulsed mid-move → ignored; each channel reaches its own goal; all_configured rises only after the slowest channel.
- rst asserted during WAIT → all outputs return to reset values next cycle. A late ps_done after reset does not change position.
